// File: rtl/conv_pkg.sv
// Shared convolution-pipeline definitions: output feature-map geometry and
// default stream field widths used by OFM producers and consumers.
package conv_pkg;

  localparam int STREAM_DATA_W  = 16;
  localparam int STREAM_COORD_W = 3;

  // Side length of a conv output map; also sizes the OFM buffer itself.
  function automatic int ofm_depth(input int ifm, input int k, input int s, input int p);
    return (ifm - k + 2 * p) / s + 1;
  endfunction

endpackage

// File: rtl/ofm_buf_reader_if.sv
// Coordinate-tagged pixel stream between the OFM reader and the next layer.
interface ofm_buf_reader_if
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = STREAM_DATA_W,
  parameter int CW         = STREAM_COORD_W
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  last_col;
  logic                  last;

  modport master (output valid, data, row, col, last_col, last, input ready);
  modport slave  (input valid, data, row, col, last_col, last, output ready);

endinterface

// File: rtl/stream_fifo3.sv
// Three-entry register FIFO, head always in slot 0; push and pop may coincide.
module stream_fifo3 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem   [3];
  logic [WIDTH-1:0] mem_n [3];
  logic [1:0]       count_n;
  logic             pop_ok;

  assign empty  = (count == 2'd0);
  assign full   = (count == 2'd3);
  assign pop_ok = pop & ~empty;
  assign dout   = mem[0];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned (no latch); blocking '=' here lets the push see the post-pop slot.
  always_comb begin
    mem_n   = mem;
    count_n = count;
    if (pop_ok) begin
      mem_n[0] = mem[1];
      mem_n[1] = mem[2];
      mem_n[2] = '0;
      count_n  = count - 2'd1;
    end
    if (push && count_n != 2'd3) begin
      for (int i = 0; i < 3; i++) begin
        if (count_n == 2'(i)) mem_n[i] = din;
      end
      count_n = count_n + 2'd1;
    end
  end

  // NOTE: storage is reset (only three words) so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      count <= 2'd0;
    end else begin
      mem   <= mem_n;
      count <= count_n;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/ofm_buf_reader.sv
// Reads one complete OFM frame from the buffer with credit-limited strobes and
// re-emits it as a row/column tagged valid/ready stream.
module ofm_buf_reader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = STREAM_DATA_W,
  parameter int IFM_SIZE    = 9,
  parameter int KERNEL_SIZE = 4,
  parameter int STRIDE      = 2,
  parameter int PAD         = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  buf_re,
  input  logic [DATA_WIDTH-1:0] buf_d,
  ofm_buf_reader_if.master      m
);

  localparam int DEPTH = ofm_depth(IFM_SIZE, KERNEL_SIZE, STRIDE, PAD);
  localparam int NPIX  = DEPTH * DEPTH;
  localparam int CW    = $clog2(DEPTH);
  localparam int NW    = $clog2(NPIX + 1);

  localparam logic [NW-1:0] NPIX_N  = NW'(NPIX);
  localparam logic [CW-1:0] EDGE_IX = CW'(DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]            state;
  logic [NW-1:0]         issued;
  logic                  re_q;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] head;
  logic [CW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  pop;

  // A strobe is only issued if the word it returns is guaranteed a FIFO slot,
  // counting the word already in flight from last cycle's strobe.
  assign buf_re = (state == READ) && (issued < NPIX_N) &&
                  (({1'b0, fifo_count} + {2'b00, re_q}) < 3'd3);
  assign busy   = (state != IDLE);
  assign pop    = m.valid & m.ready;

  assign m.valid    = ~fifo_empty;
  assign m.data     = head;
  assign m.row      = row;
  assign m.col      = col;
  assign m.last_col = (col == EDGE_IX);
  assign m.last     = (row == EDGE_IX) && (col == EDGE_IX);

  stream_fifo3 #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (re_q),
    .din   (buf_d),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      issued <= '0;
      re_q   <= 1'b0;
      done   <= 1'b0;
      row    <= '0;
      col    <= '0;
    end else begin
      re_q <= buf_re;
      done <= 1'b0;
      if (buf_re) issued <= issued + 1'b1;

      case (state)
        IDLE: if (start) begin
          state  <= READ;
          issued <= '0;
        end
        READ:  if (issued == NPIX_N) state <= DRAIN;
        DRAIN: if (pop && m.last) begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase

      // Coordinates describe the head pixel, so they move only on a pop.
      if (pop) begin
        if (m.last) begin
          row <= '0;
          col <= '0;
        end else if (col == EDGE_IX) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
